// File: rtl/agat_mem_pkg.sv
// agat_mem_pkg: shared types and byte-enable constants for the Agat-9 RAM arbiter
package agat_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;
  typedef enum logic {CPU, VIDEO} grant_t;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/agat_acc_timer.sv
// agat_acc_timer: 4-bit load/count-down strobe timer, last flags the final strobe cycle
module agat_acc_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       last
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? 4'd0 : cnt_d;
  assign last = cnt_q == 4'd0;
endmodule

// File: rtl/agat_ram_arbiter.sv
// agat_ram_arbiter: round-robin CPU/video sharing of the 16-bit system RAM with fixed-length strobes
module agat_ram_arbiter
  import agat_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_byte,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_nwait,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [15:0]       vid_rdata,
  output logic              vid_ack,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [1:0]        ram_be,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_datain,
  input  logic [15:0]       ram_dataout
);
  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d, last_grant_q, last_grant_d, pick;
  logic              we_q, we_d, lane_q, lane_d;
  logic              ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [1:0]        ram_be_q, ram_be_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [15:0]       ram_datain_q, ram_datain_d, vid_rdata_q, vid_rdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic              any_req, pick_we, timer_last;
  assign any_req = cpu_req | vid_req;
  // video wins a conflict unless it was the previous grant
  assign pick    = (vid_req && (!cpu_req || last_grant_q == CPU)) ? VIDEO : CPU;
  assign pick_we = pick == CPU && cpu_we;
  agat_acc_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == IDLE && any_req),
    .en       (state_q == ACCESS),
    .load_val (4'(ACCESS_CYCLES - 1)),
    .last     (timer_last)
  );
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    we_d          = we_q;
    lane_d        = lane_q;
    ram_rd_d      = ram_rd_q;
    ram_wr_d      = ram_wr_q;
    ram_be_d      = ram_be_q;
    ram_address_d = ram_address_q;
    ram_datain_d  = ram_datain_q;
    cpu_rdata_d   = cpu_rdata_q;
    vid_rdata_d   = vid_rdata_q;
    cpu_ack_d     = 1'b0;
    vid_ack_d     = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d       = ACCESS;
        grant_d       = pick;
        last_grant_d  = pick;
        we_d          = pick_we;
        lane_d        = cpu_byte;
        ram_rd_d      = !pick_we;
        ram_wr_d      = pick_we;
        ram_be_d      = pick_we ? (cpu_byte ? BE_HI : BE_LO) : BE_WORD;
        ram_address_d = pick == VIDEO ? vid_addr : cpu_addr;
        ram_datain_d  = pick == CPU ? {cpu_wdata, cpu_wdata} : ram_datain_q;
      end
      ACCESS: if (timer_last) begin
        state_d     = ACK;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        cpu_ack_d   = grant_q == CPU;
        vid_ack_d   = grant_q == VIDEO;
        vid_rdata_d = grant_q == VIDEO ? ram_dataout : vid_rdata_q;
        cpu_rdata_d = (grant_q == CPU && !we_q) ? (lane_q ? ram_dataout[15:8] : ram_dataout[7:0]) : cpu_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= CPU;
      last_grant_q  <= CPU;
      we_q          <= 1'b0;
      lane_q        <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_be_q      <= 2'b00;
      ram_address_q <= '0;
      ram_datain_q  <= '0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      lane_q        <= lane_d;
      ram_rd_q      <= ram_rd_d;
      ram_wr_q      <= ram_wr_d;
      ram_be_q      <= ram_be_d;
      ram_address_q <= ram_address_d;
      ram_datain_q  <= ram_datain_d;
      cpu_rdata_q   <= cpu_rdata_d;
      vid_rdata_q   <= vid_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      vid_ack_q     <= vid_ack_d;
    end
  end
  assign ram_rd      = ram_rd_q;
  assign ram_wr      = ram_wr_q;
  assign ram_be      = ram_be_q;
  assign ram_address = ram_address_q;
  assign ram_datain  = ram_datain_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign cpu_nwait   = ~cpu_req | cpu_ack_q;
endmodule
